// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS32 core.
// Latches decode results for EX, detects load-use hazards (stalling PC and
// IF/ID while a bubble enters EX), honours branch flush and a global hold,
// and counts injected bubbles with a saturating counter.
module id_ex_stage_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [DW-1:0]   DR1,
  input  logic [DW-1:0]   DR2,
  input  logic [DW-1:0]   salida_SE,
  input  logic [DW-1:0]   pc4_id,
  input  logic [RW-1:0]   rs_id,
  input  logic [RW-1:0]   rt_id,
  input  logic [RW-1:0]   rd_id,
  input  logic [9:0]      ctrl_id,
  output logic [DW-1:0]   DR1_ex,
  output logic [DW-1:0]   DR2_ex,
  output logic [DW-1:0]   SE_ex,
  output logic [DW-1:0]   pc4_ex,
  output logic [RW-1:0]   rs_ex,
  output logic [RW-1:0]   rt_ex,
  output logic [RW-1:0]   rd_ex,
  output logic [9:0]      ctrl_ex,
  output logic            stall,
  output logic [CNTW-1:0] bubble_cnt
);

  // Control word layout: {RegWrite, MemRead, MemWrite, MemToReg, RegDst,
  // ALUSrc, Branch, ALUOp[2:0]}; only MemRead matters to this block.
  localparam int MemReadBit = 8;

  logic [DW-1:0]   dr1_q, dr1_d;
  logic [DW-1:0]   dr2_q, dr2_d;
  logic [DW-1:0]   se_q, se_d;
  logic [DW-1:0]   pc4_q, pc4_d;
  logic [RW-1:0]   rs_q, rs_d;
  logic [RW-1:0]   rt_q, rt_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [9:0]      ctrl_q, ctrl_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic haz;
  logic insert_bubble;

  // Load-use detection: the load in EX writes rt, which the ID instruction
  // reads; register $0 is hardwired to zero and never creates a dependency.
  always_comb begin
    haz = ctrl_q[MemReadBit] && (rt_q != '0) &&
          ((rt_q == rs_id) || (rt_q == rt_id));
    // A flush already squashes the ID instruction, so stalling it is pointless.
    stall = haz && !flush && !reset;
    insert_bubble = flush || haz;
  end

  // Next-state selection: hold freezes everything, a bubble zeroes all
  // fields (all-zero control is a NOP), otherwise load from decode.
  always_comb begin
    dr1_d        = dr1_q;
    dr2_d        = dr2_q;
    se_d         = se_q;
    pc4_d        = pc4_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!hold) begin
      if (insert_bubble) begin
        dr1_d  = '0;
        dr2_d  = '0;
        se_d   = '0;
        pc4_d  = '0;
        rs_d   = '0;
        rt_d   = '0;
        rd_d   = '0;
        ctrl_d = '0;
        if (bubble_cnt_q != {CNTW{1'b1}}) begin
          bubble_cnt_d = bubble_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end else begin
        dr1_d  = DR1;
        dr2_d  = DR2;
        se_d   = salida_SE;
        pc4_d  = pc4_id;
        rs_d   = rs_id;
        rt_d   = rt_id;
        rd_d   = rd_id;
        ctrl_d = ctrl_id;
      end
    end
  end

  // Pipeline register state with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr1_q        <= '0;
      dr2_q        <= '0;
      se_q         <= '0;
      pc4_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      dr1_q        <= dr1_d;
      dr2_q        <= dr2_d;
      se_q         <= se_d;
      pc4_q        <= pc4_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign DR1_ex     = dr1_q;
  assign DR2_ex     = dr2_q;
  assign SE_ex      = se_q;
  assign pc4_ex     = pc4_q;
  assign rs_ex      = rs_q;
  assign rt_ex      = rt_q;
  assign rd_ex      = rd_q;
  assign ctrl_ex    = ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the EX-side register contents.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        flush;
  logic [31:0] DR1, DR2, salida_SE, pc4_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic [9:0]  ctrl_id;

  logic [31:0] DR1_ex, DR2_ex, SE_ex, pc4_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [9:0]  ctrl_ex;
  logic        stall;
  logic [15:0] bubble_cnt;

  // Small-counter instance used for the saturation scenario
  logic [31:0] s_dr1, s_dr2, s_se, s_pc4;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [9:0]  s_ctrl;
  logic        s_stall;
  logic [1:0]  s_cnt;

  int checks;
  int errors;

  // Behavioural model of what EX should hold
  logic [31:0] m_dr1, m_dr2, m_se, m_pc4;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [9:0]  m_ctrl;
  int          m_cnt;

  logic [152:0] act_fields;
  logic [152:0] exp_fields;
  assign act_fields = {DR1_ex, DR2_ex, SE_ex, pc4_ex, rs_ex, rt_ex, rd_ex, ctrl_ex};
  assign exp_fields = {m_dr1, m_dr2, m_se, m_pc4, m_rs, m_rt, m_rd, m_ctrl};

  localparam logic [9:0] CtrlLw  = 10'h350;
  localparam logic [9:0] CtrlAdd = 10'h2A1;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .DR1(DR1), .DR2(DR2), .salida_SE(salida_SE), .pc4_id(pc4_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .ctrl_id(ctrl_id),
    .DR1_ex(DR1_ex), .DR2_ex(DR2_ex), .SE_ex(SE_ex), .pc4_ex(pc4_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .ctrl_ex(ctrl_ex),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_reg #(.CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .DR1(DR1), .DR2(DR2), .salida_SE(salida_SE), .pc4_id(pc4_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .ctrl_id(ctrl_id),
    .DR1_ex(s_dr1), .DR2_ex(s_dr2), .SE_ex(s_se), .pc4_ex(s_pc4),
    .rs_ex(s_rs), .rt_ex(s_rt), .rd_ex(s_rd), .ctrl_ex(s_ctrl),
    .stall(s_stall), .bubble_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_haz();
    return m_ctrl[8] && (m_rt != 5'd0) && ((m_rt == rs_id) || (m_rt == rt_id));
  endfunction

  function automatic bit model_stall();
    return model_haz() && !flush && !reset;
  endfunction

  task automatic model_clear();
    m_dr1 = '0; m_dr2 = '0; m_se = '0; m_pc4 = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
  endtask

  // Apply the per-edge rules to the model using the inputs present at the edge
  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (hold) begin
      // nothing changes
    end else if (flush || model_haz()) begin
      m_dr1 = '0; m_dr2 = '0; m_se = '0; m_pc4 = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_dr1 = DR1; m_dr2 = DR2; m_se = salida_SE; m_pc4 = pc4_id;
      m_rs = rs_id; m_rt = rt_id; m_rd = rd_id; m_ctrl = ctrl_id;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    DR1 = $urandom; DR2 = $urandom; salida_SE = $urandom; pc4_id = $urandom;
    ctrl_id = c; rs_id = rs; rt_id = rt; rd_id = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(CtrlAdd, 5'd1, 5'd2, 5'd3);
    model_clear();
    #12;
    reset = 1'b0;
    tick();
    set_id(CtrlLw, 5'd4, 5'd8, 5'd0);
    tick();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (act_fields !== '0 || bubble_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: fields=%h cnt=%0d expected 0/0", act_fields, bubble_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stall: stall=%b expected 0", stall);
    end
    model_clear();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_normal_flow();
    DR1 = 32'h0000_0005; DR2 = 32'hFFFF_FFFE; salida_SE = 32'h0000_0010;
    pc4_id = 32'h0040_0004; rs_id = 5'd1; rt_id = 5'd2; rd_id = 5'd3; ctrl_id = CtrlAdd;
    tick();
    checks++;
    if (DR1_ex !== 32'h5 || DR2_ex !== 32'hFFFF_FFFE || SE_ex !== 32'h10 ||
        ctrl_ex !== 10'h2A1 || pc4_ex !== 32'h0040_0004) begin
      errors++;
      $display("[TB] FAIL normal_flow: got %h %h %h %h ctrl %h", DR1_ex, DR2_ex, SE_ex,
               pc4_ex, ctrl_ex);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL normal_stall: stall=%b expected 0", stall);
    end
  endtask

  task automatic test_load_use();
    int cnt0;
    set_id(CtrlLw, 5'd4, 5'd8, 5'd0);
    tick();
    cnt0 = m_cnt;
    set_id(CtrlAdd, 5'd8, 5'd2, 5'd9);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_stall: stall=%b expected 1", stall);
    end
    tick();
    checks++;
    if (ctrl_ex !== 10'd0 || bubble_cnt !== 16'(cnt0 + 1)) begin
      errors++;
      $display("[TB] FAIL load_use_bubble: ctrl=%h cnt=%0d expected 0/%0d", ctrl_ex,
               bubble_cnt, cnt0 + 1);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_release: stall=%b expected 0", stall);
    end
    tick();
    checks++;
    if (act_fields !== exp_fields || ctrl_ex !== CtrlAdd || rs_ex !== 5'd8) begin
      errors++;
      $display("[TB] FAIL load_use_represent: got %h expected %h", act_fields, exp_fields);
    end
  endtask

  task automatic test_zero_reg();
    set_id(CtrlLw, 5'd4, 5'd0, 5'd0);
    tick();
    set_id(CtrlAdd, 5'd0, 5'd0, 5'd5);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_reg: stall=%b expected 0", stall);
    end
    tick();
    set_id(CtrlLw, 5'd4, 5'd9, 5'd0);
    tick();
    set_id(CtrlAdd, 5'd3, 5'd4, 5'd5);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_match: stall=%b expected 0", stall);
    end
    tick();
  endtask

  task automatic test_flush_vs_hazard();
    int cnt0;
    set_id(CtrlLw, 5'd4, 5'd8, 5'd0);
    tick();
    cnt0 = m_cnt;
    set_id(CtrlAdd, 5'd8, 5'd8, 5'd1);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall: stall=%b expected 0", stall);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (act_fields !== '0 || bubble_cnt !== 16'(cnt0 + 1)) begin
      errors++;
      $display("[TB] FAIL flush_bubble: fields=%h cnt=%0d expected 0/%0d", act_fields,
               bubble_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_hold();
    logic [152:0] snap;
    logic [15:0]  cnt_snap;
    set_id(CtrlLw, 5'd6, 5'd7, 5'd0);
    tick();
    snap = exp_fields;
    cnt_snap = 16'(m_cnt);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(10'($urandom), 5'(i == 0 ? 7 : $urandom), 5'($urandom), 5'($urandom));
      flush = (i == 1);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++;
        $display("[TB] FAIL hold_stall: stall=%b expected %b", stall, model_stall());
      end
      tick();
      checks++;
      if (act_fields !== snap || bubble_cnt !== cnt_snap) begin
        errors++;
        $display("[TB] FAIL hold_frozen: fields=%h cnt=%0d expected %h/%0d", act_fields,
                 bubble_cnt, snap, cnt_snap);
      end
    end
    hold = 1'b0;
    flush = 1'b0;
    set_id(CtrlAdd, 5'd1, 5'd2, 5'd3);
    tick();
  endtask

  task automatic test_saturation();
    #2;
    reset = 1'b1;
    model_clear();
    #2;
    reset = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b0;
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++;
      $display("[TB] FAIL saturation_small: cnt=%0d expected 3", s_cnt);
    end
    checks++;
    if (bubble_cnt !== 16'd5) begin
      errors++;
      $display("[TB] FAIL saturation_wide: cnt=%0d expected 5", bubble_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [4:0] rs;
      logic [4:0] rt;
      logic [9:0] c;
      rs = 5'($urandom);
      rt = 5'($urandom);
      if ($urandom_range(0, 2) == 0) rs = m_rt;
      if ($urandom_range(0, 5) == 0) rt = m_rt;
      c = 10'($urandom);
      if ($urandom_range(0, 2) == 0) c[8] = 1'b1;
      set_id(c, rs, rt, 5'($urandom));
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++;
        $display("[TB] FAIL random_stall: cycle %0d stall=%b expected %b", i, stall,
                 model_stall());
      end
      tick();
      checks++;
      if (act_fields !== exp_fields || bubble_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("[TB] FAIL random_fields: cycle %0d got %h/%0d expected %h/%0d", i,
                 act_fields, bubble_cnt, exp_fields, m_cnt);
      end
    end
    hold = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_flow();
    test_load_use();
    test_zero_reg();
    test_flush_vs_hazard();
    test_hold();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
